// File: rtl/my_alu_pkg.sv
// Shared types and constants for the registered Hack-style ALU.
//   alu_state_t : sequencing state of the ALU pipe (IDLE, MUL, DONE)
//   alu_ctrl_t  : the six Hack controls plus the multiply-mode select
//   CTRL_*      : six-bit Hack encodings, ordered {zx,nx,zy,ny,f,no}
package my_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
        logic mul;
    } alu_ctrl_t;

    localparam logic [5:0] CTRL_ADD    = 6'b000010;  // x + y
    localparam logic [5:0] CTRL_SUB_XY = 6'b010011;  // x - y
    localparam logic [5:0] CTRL_AND    = 6'b000000;  // x & y
    localparam logic [5:0] CTRL_ZERO   = 6'b101010;  // 0
    localparam logic [5:0] CTRL_ONE    = 6'b111111;  // 1
    localparam logic [5:0] CTRL_NEG1   = 6'b111010;  // -1

    // Build a control word from a six-bit Hack encoding and the multiply select.
    function automatic alu_ctrl_t make_ctrl(input logic [5:0] hack, input logic mul);
        alu_ctrl_t c;
        c = '{zx: hack[5], nx: hack[4], zy: hack[3], ny: hack[2],
              f: hack[1], no: hack[0], mul: mul};
        return c;
    endfunction

endpackage

// File: rtl/my_alu_pipe_if.sv
// Request/response bundle of the ALU pipe.
//   request  : in_valid/in_ready handshake, operands x/y, Hack controls, mul
//   response : out_valid/out_ready handshake, out, zr/ng/ov flags, busy
// modport master : the producer/consumer side (decode + writeback)
// modport slave  : the ALU pipe itself
interface my_alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             mul;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             ov;
    logic             busy;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        input  in_ready, out_valid, out, zr, ng, ov, busy
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        output in_ready, out_valid, out, zr, ng, ov, busy
    );
endinterface

// File: rtl/my_alu_core.sv
// Combinational Hack ALU datapath at WIDTH bits.
//   x, y          : raw operands
//   zx..no        : Hack controls
//   xp, yp        : pre-processed operands (also used as multiply inputs)
//   res           : (f ? xp+yp : xp&yp) ^ {WIDTH{no}}
//   zr, ng        : res == 0, res sign bit
//   ov            : signed overflow of xp+yp (before 'no'), 0 for the AND path
module my_alu_core
    #(
        parameter int WIDTH = 16
    )
    (
        input  logic [WIDTH-1:0] x,
        input  logic [WIDTH-1:0] y,
        input  logic             zx,
        input  logic             nx,
        input  logic             zy,
        input  logic             ny,
        input  logic             f,
        input  logic             no,
        output logic [WIDTH-1:0] xp,
        output logic [WIDTH-1:0] yp,
        output logic [WIDTH-1:0] res,
        output logic             zr,
        output logic             ng,
        output logic             ov
    );

    logic [WIDTH-1:0] xz_s;
    logic [WIDTH-1:0] yz_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] pre_s;

    // Operand pre-processing, function select, output inversion and flags.
    always_comb begin
        xz_s  = zx ? {WIDTH{1'b0}} : x;
        yz_s  = zy ? {WIDTH{1'b0}} : y;
        xp    = nx ? ~xz_s : xz_s;
        yp    = ny ? ~yz_s : yz_s;
        // Carry-out is dropped: arithmetic is modulo 2^WIDTH.
        sum_s = xp + yp;
        pre_s = f ? sum_s : (xp & yp);
        res   = pre_s ^ {WIDTH{no}};
        zr    = (res == {WIDTH{1'b0}});
        ng    = res[WIDTH-1];
        // Same-sign operands producing a different-sign sum is a signed overflow.
        ov    = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum_s[WIDTH-1] != xp[WIDTH-1]);
    end

endmodule

// File: rtl/my_alu_pipe.sv
// Registered Hack-style ALU with a shift-add multiply mode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : my_alu_pipe_if.slave -- op request handshake, operands and
//           controls in; registered result, flags, out_valid and busy out.
// One op is in flight at a time. ALU ops take one cycle; multiplies iterate
// WIDTH cycles in MUL before the result appears in DONE. A result held in
// DONE can be handed off in the same cycle a new op is accepted.
module my_alu_pipe
    import my_alu_pkg::*;
    #(
        parameter int WIDTH = 16
    )
    (
        input  logic              clk,
        input  logic              rst_n,
        my_alu_pipe_if.slave      bus
    );

    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             ov_q, ov_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             no_q, no_d;

    alu_ctrl_t        ctrl_in_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] xp_s, yp_s, res_s;
    logic             core_zr_s, core_ng_s, core_ov_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0] mul_res_s;

    assign ctrl_in_s  = '{zx: bus.zx, nx: bus.nx, zy: bus.zy, ny: bus.ny,
                          f: bus.f, no: bus.no, mul: bus.mul};
    assign in_ready_s = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;

    my_alu_core #(.WIDTH(WIDTH)) u_core (
        .x   (bus.x),
        .y   (bus.y),
        .zx  (ctrl_in_s.zx),
        .nx  (ctrl_in_s.nx),
        .zy  (ctrl_in_s.zy),
        .ny  (ctrl_in_s.ny),
        .f   (ctrl_in_s.f),
        .no  (ctrl_in_s.no),
        .xp  (xp_s),
        .yp  (yp_s),
        .res (res_s),
        .zr  (core_zr_s),
        .ng  (core_ng_s),
        .ov  (core_ov_s)
    );

    // One shift-add step; the final step's value is the product.
    always_comb begin
        acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_res_s  = acc_step_s ^ {WIDTH{no_q}};
    end

    // Next-state, multiply datapath and output register updates.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
        ov_d     = ov_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        no_d     = no_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    out_d   = mul_res_s;
                    zr_d    = (mul_res_s == {WIDTH{1'b0}});
                    ng_d    = mul_res_s[WIDTH-1];
                    ov_d    = 1'b0;
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accepted op (from IDLE, or from DONE during handoff) overrides the above.
        if (accept_s) begin
            if (ctrl_in_s.mul) begin
                state_d  = MUL;
                acc_d    = {WIDTH{1'b0}};
                mcand_d  = xp_s;
                mplier_d = yp_s;
                cnt_d    = CNT_W'(WIDTH);
                no_d     = ctrl_in_s.no;
            end else begin
                state_d  = DONE;
                out_d    = res_s;
                zr_d     = core_zr_s;
                ng_d     = core_ng_s;
                ov_d     = core_ov_s;
            end
        end else begin
            no_d = no_d;
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == MUL);
    end

    // State, datapath and output flops with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= {WIDTH{1'b0}};
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            ov_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= {WIDTH{1'b0}};
            mcand_q     <= {WIDTH{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            no_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            ov_q        <= ov_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            no_q        <= no_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.ov        = ov_q;
    assign bus.busy      = busy_q;

endmodule
